step_updown_counter: RTL

- Parametrised successor to the team's basic up/down counter.
- Counts between MIN_VALUE and MAX_VALUE with a programmable per-cycle step and a synchronous parallel load.
- Selectable saturate or wrap behaviour at the range limits, with a one-cycle wrap pulse.
- Used as a timebase, address generator, or PWM/phase accumulator inside larger blocks.

---
 rtl/step_updown_counter.sv | 108 ++++++++++
 1 files changed

// File: rtl/step_updown_counter.sv
// Up/down counter with a programmable step, bounded range,
// parallel load and selectable saturate or wrap at the bounds.
module step_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4,
    parameter int MAX_VALUE  = 2**WIDTH-1,
    parameter int MIN_VALUE  = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ClkEnable,
    input  logic                  Stop,
    input  logic                  UpDownMode,
    input  logic                  WrapMode,
    input  logic                  Load,
    input  logic [WIDTH-1:0]      LoadValue,
    input  logic [STEP_WIDTH-1:0] Step,
    output logic [WIDTH-1:0]      Output,
    output logic                  LimitReachedFlag,
    output logic                  WrapPulse,
    output logic                  AtMax,
    output logic                  AtMin
);

    // One guard bit above the widest sum keeps the arithmetic signed
    // and free of intermediate overflow.
    localparam int SW = WIDTH + STEP_WIDTH + 1;
    typedef logic signed [SW-1:0] acc_t;

    localparam acc_t MAX_A   = acc_t'(MAX_VALUE);
    localparam acc_t MIN_A   = acc_t'(MIN_VALUE);
    localparam acc_t RANGE_A = acc_t'(MAX_VALUE - MIN_VALUE + 1);

    if (MIN_VALUE >= MAX_VALUE) begin : g_bad_range
        $error("step_updown_counter: MIN_VALUE must be below MAX_VALUE");
    end

    acc_t             cur;
    acc_t             stp;
    acc_t             cand;
    acc_t             ldv;
    logic [WIDTH-1:0] nxt_out;
    logic             nxt_lim;
    logic             nxt_wrap;

    // Next-state: hold, load with clamping, or step with saturate/wrap.
    always_comb begin
        cur      = acc_t'(Output);
        stp      = (acc_t'(Step) > RANGE_A) ? RANGE_A : acc_t'(Step);
        cand     = UpDownMode ? (cur + stp) : (cur - stp);
        ldv      = acc_t'(LoadValue);
        nxt_out  = Output;
        nxt_lim  = LimitReachedFlag;
        nxt_wrap = 1'b0;
        if (ClkEnable) begin
            if (Load) begin
                if (ldv > MAX_A) begin
                    nxt_out = WIDTH'(MAX_VALUE);
                    nxt_lim = 1'b1;
                end else if (ldv < MIN_A) begin
                    nxt_out = WIDTH'(MIN_VALUE);
                    nxt_lim = 1'b1;
                end else begin
                    nxt_out = LoadValue;
                    nxt_lim = 1'b0;
                end
            end else if (!Stop) begin
                if (UpDownMode && (cand > MAX_A)) begin
                    nxt_lim = 1'b1;
                    if (WrapMode) begin
                        nxt_out  = WIDTH'(cand - RANGE_A);
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_out = WIDTH'(MAX_VALUE);
                    end
                end else if (!UpDownMode && (cand < MIN_A)) begin
                    nxt_lim = 1'b1;
                    if (WrapMode) begin
                        nxt_out  = WIDTH'(cand + RANGE_A);
                        nxt_wrap = 1'b1;
                    end else begin
                        nxt_out = WIDTH'(MIN_VALUE);
                    end
                end else begin
                    nxt_out = WIDTH'(cand);
                    nxt_lim = 1'b0;
                end
            end
        end
    end

    // State register with asynchronous reset to the lower bound.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Output           <= WIDTH'(MIN_VALUE);
            LimitReachedFlag <= 1'b0;
            WrapPulse        <= 1'b0;
        end else begin
            Output           <= nxt_out;
            LimitReachedFlag <= nxt_lim;
            WrapPulse        <= nxt_wrap;
        end
    end

    assign AtMax = (Output == WIDTH'(MAX_VALUE));
    assign AtMin = (Output == WIDTH'(MIN_VALUE));

endmodule
